// File: rtl/pipe_pkg.sv
// Shared definitions for the secure elastic pipeline.
//   clog2_min1 : bit width needed to hold values 0..n-1, never less than 1
//   DROP_SAT   : saturation value of the discarded-item counter at its default width
package pipe_pkg;

  localparam int unsigned DROP_CNT_W_DEF = 16;
  localparam logic [DROP_CNT_W_DEF-1:0] DROP_SAT = '1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/secure_pipe_stage.sv
// One register stage of the secure elastic pipeline.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   flush              synchronous clear of this stage (wins over adv)
//   adv                stage may take a new item from its predecessor this edge
//   prev_valid/data    item offered by the predecessor (or the input port)
//   valid/data         current stage contents; data is zero whenever valid is low
module secure_pipe_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              adv,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (adv) begin
      // Loading a bubble scrubs the payload so stale data never lingers.
      valid <= prev_valid;
      data  <= prev_valid ? prev_data : '0;
    end
  end

endmodule

// File: rtl/secure_elastic_pipeline.sv
// Elastic valid/ready register pipeline with bubble collapsing, secure zeroing of
// empty stages, synchronous flush, live occupancy and a saturating drop counter.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   in_data/valid/ready   producer handshake (stage 0 side)
//   flush                 clears every stage; counts valid items destroyed
//   out_data/valid/ready  consumer handshake (last stage side)
//   occupancy             number of valid stages
//   drop_count            saturating total of items discarded by flushes
module secure_elastic_pipeline
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned DROP_CNT_W = 16,
  localparam int unsigned OCC_W     = clog2_min1(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int unsigned SUM_W = ((DROP_CNT_W > OCC_W) ? DROP_CNT_W : OCC_W) + 1;
  localparam logic [SUM_W-1:0] SAT_EXT = (SUM_W'(1) << DROP_CNT_W) - SUM_W'(1);

  logic [DEPTH-1:0]  stage_valid;
  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic              adv_chain;
  logic              accept;
  logic              deliver;

  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [SUM_W-1:0]      drop_sum;

  // A stage can take a new item when it is empty or its own item moves on.
  // Walking from the output back makes any hole ahead open every stage behind it.
  always_comb begin
    adv       = '0;
    adv_chain = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_chain = !stage_valid[i] || adv_chain;
      adv[i]    = adv_chain;
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign out_valid = stage_valid[DEPTH-1] && !flush;
  assign out_data  = stage_data[DEPTH-1];
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              prev_valid;
    logic [DATA_W-1:0] prev_data;

    if (i == 0) begin : g_head
      assign prev_valid = accept;
      assign prev_data  = in_data;
    end else begin : g_body
      assign prev_valid = stage_valid[i-1];
      assign prev_data  = stage_data[i-1];
    end

    secure_pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .adv       (adv[i]),
      .prev_valid(prev_valid),
      .prev_data (prev_data),
      .valid     (stage_valid[i]),
      .data      (stage_data[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !deliver) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && deliver) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Widened sum so the saturation test cannot itself overflow.
  always_comb begin
    drop_sum = SUM_W'(drop_q) + SUM_W'(occ_q);
    drop_d   = drop_q;
    if (flush) begin
      drop_d = (drop_sum > SAT_EXT) ? DROP_CNT_W'(SAT_EXT) : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  assign occupancy  = occ_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_secure_elastic_pipeline.sv
// Bench for secure_elastic_pipeline: three instances (DEPTH 3/16-bit counter,
// DEPTH 3/2-bit counter, DEPTH 1) checked every cycle against a slot-level model,
// plus directed scenarios with literal expectations.
module tb_secure_elastic_pipeline;

  localparam int NDUT = 3;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data   [NDUT];
  logic          in_valid  [NDUT];
  logic          in_ready  [NDUT];
  logic          flush     [NDUT];
  logic [DW-1:0] out_data  [NDUT];
  logic          out_valid [NDUT];
  logic          out_ready [NDUT];

  logic [1:0]  occ0, occ1;
  logic [0:0]  occ2;
  logic [15:0] drop0, drop2;
  logic [1:0]  drop1;

  int n_cmp = 0;
  int n_bad = 0;

  secure_elastic_pipeline #(.DATA_W(DW), .DEPTH(3), .DROP_CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .flush(flush[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .occupancy(occ0),
    .drop_count(drop0)
  );

  secure_elastic_pipeline #(.DATA_W(DW), .DEPTH(3), .DROP_CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .flush(flush[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .occupancy(occ1),
    .drop_count(drop1)
  );

  secure_elastic_pipeline #(.DATA_W(DW), .DEPTH(1), .DROP_CNT_W(16)) u_dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .flush(flush[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .occupancy(occ2),
    .drop_count(drop2)
  );

  function automatic int dep_of(input int id);
    return (id == 2) ? 1 : 3;
  endfunction

  function automatic int drop_max(input int id);
    return (id == 1) ? 3 : 65535;
  endfunction

  function automatic int act_occ(input int id);
    case (id)
      0:       return int'(occ0);
      1:       return int'(occ1);
      default: return int'(occ2);
    endcase
  endfunction

  function automatic int act_drop(input int id);
    case (id)
      0:       return int'(drop0);
      1:       return int'(drop1);
      default: return int'(drop2);
    endcase
  endfunction

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, id, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots 0..d-1 per instance; an item steps one slot toward the output each edge
  // if the consumer is taking data or there is any empty slot ahead of it.
  logic          m_v [NDUT][3];
  logic [DW-1:0] m_d [NDUT][3];
  int            m_drop [NDUT];

  function automatic int m_cnt(input int id);
    int c = 0;
    for (int p = 0; p < dep_of(id); p++) c += m_v[id][p] ? 1 : 0;
    return c;
  endfunction

  task automatic model_clear(input int id);
    for (int p = 0; p < 3; p++) begin
      m_v[id][p] = 1'b0;
      m_d[id][p] = '0;
    end
  endtask

  task automatic model_step(input int id);
    int d, cnt;
    logic nv [3];
    logic [DW-1:0] nd [3];
    bit hole_ahead;
    d   = dep_of(id);
    cnt = m_cnt(id);
    if (flush[id]) begin
      m_drop[id] = (m_drop[id] + cnt > drop_max(id)) ? drop_max(id) : m_drop[id] + cnt;
      model_clear(id);
    end else begin
      for (int p = 0; p < 3; p++) begin
        nv[p] = 1'b0;
        nd[p] = '0;
      end
      for (int p = 0; p < d; p++) begin
        if (m_v[id][p]) begin
          hole_ahead = 1'b0;
          for (int q = p + 1; q < d; q++) if (!m_v[id][q]) hole_ahead = 1'b1;
          if (p == d - 1) begin
            if (!out_ready[id]) begin
              nv[p] = 1'b1;
              nd[p] = m_d[id][p];
            end
          end else if (out_ready[id] || hole_ahead) begin
            nv[p+1] = 1'b1;
            nd[p+1] = m_d[id][p];
          end else begin
            nv[p] = 1'b1;
            nd[p] = m_d[id][p];
          end
        end
      end
      if (in_valid[id] && (out_ready[id] || cnt < d)) begin
        nv[0] = 1'b1;
        nd[0] = in_data[id];
      end
      for (int p = 0; p < 3; p++) begin
        m_v[id][p] = nv[p];
        m_d[id][p] = nd[p];
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int id = 0; id < NDUT; id++) begin
        model_clear(id);
        m_drop[id] = 0;
      end
    end else begin
      for (int id = 0; id < NDUT; id++) model_step(id);
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      for (int id = 0; id < NDUT; id++) begin
        int d, cnt;
        d   = dep_of(id);
        cnt = m_cnt(id);
        chk("m_in_ready", id, int'(in_ready[id]),
            int'(!flush[id] && (out_ready[id] || cnt < d)));
        chk("m_out_valid", id, int'(out_valid[id]), int'(m_v[id][d-1] && !flush[id]));
        chk("m_out_data", id, int'(out_data[id]), m_v[id][d-1] ? int'(m_d[id][d-1]) : 0);
        chk("m_occupancy", id, act_occ(id), cnt);
        chk("m_drop_count", id, act_drop(id), m_drop[id]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic fill(input int id, input int n);
    out_ready[id] = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid[id] = 1'b1;
      in_data[id]  = DW'($urandom_range(1, 65535));
      at_neg();
      chk("fill_ready", id, int'(in_ready[id]), 1);
      tick();
    end
    in_valid[id] = 1'b0;
  endtask

  // Flush for ncyc edges while the producer keeps offering an item.
  task automatic flush_for(input int id, input int ncyc, input int exp_drop);
    flush[id]    = 1'b1;
    in_valid[id] = 1'b1;
    in_data[id]  = 16'hBEEF;
    for (int i = 0; i < ncyc; i++) begin
      at_neg();
      chk("flush_out_valid", id, int'(out_valid[id]), 0);
      chk("flush_in_ready", id, int'(in_ready[id]), 0);
      tick();
    end
    flush[id]    = 1'b0;
    in_valid[id] = 1'b0;
    at_neg();
    chk("post_flush_occ", id, act_occ(id), 0);
    chk("post_flush_data", id, int'(out_data[id]), 0);
    chk("post_flush_drop", id, act_drop(id), exp_drop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int id = 0; id < NDUT; id++) begin
      in_data[id]   = '0;
      in_valid[id]  = 1'b0;
      flush[id]     = 1'b0;
      out_ready[id] = 1'b0;
    end
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 0, int'(out_valid[0]), 0);
    chk("rst_out_data", 0, int'(out_data[0]), 0);
    chk("rst_occ", 0, act_occ(0), 0);
    chk("rst_drop", 0, act_drop(0), 0);
    #19 reset = 1'b0;
    tick();
    at_neg();
    chk("rst_in_ready", 0, int'(in_ready[0]), 1);
    tick();

    // 1. Streaming: A0..A4 back-to-back, first out after the third edge.
    out_ready[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid[0] = (k < 5);
      in_data[0]  = DW'(16'hA0 + k);
      at_neg();
      chk("stream_in_ready", 0, int'(in_ready[0]), 1);
      if (k >= 3) begin
        chk("stream_valid", 0, int'(out_valid[0]), 1);
        chk("stream_data", 0, int'(out_data[0]), 16'hA0 + k - 3);
      end else begin
        chk("stream_valid", 0, int'(out_valid[0]), 0);
      end
      if (k == 3) chk("stream_occ", 0, act_occ(0), 3);
      tick();
    end
    in_valid[0] = 1'b0;
    tick();
    tick();

    // 2. Backpressure fill.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'h11;
    at_neg(); chk("bp_ready1", 0, int'(in_ready[0]), 1); tick();
    in_data[0] = 16'h22;
    at_neg(); chk("bp_ready2", 0, int'(in_ready[0]), 1); tick();
    in_data[0] = 16'h33;
    at_neg(); chk("bp_ready3", 0, int'(in_ready[0]), 1); tick();
    in_data[0] = 16'h44;
    at_neg();
    chk("bp_full_ready", 0, int'(in_ready[0]), 0);
    chk("bp_full_occ", 0, act_occ(0), 3);
    chk("bp_full_data", 0, int'(out_data[0]), 16'h11);
    tick();
    at_neg(); chk("bp_held_ready", 0, int'(in_ready[0]), 0);
    tick();
    out_ready[0] = 1'b1;
    at_neg();
    chk("bp_release_ready", 0, int'(in_ready[0]), 1);
    chk("bp_release_data", 0, int'(out_data[0]), 16'h11);
    tick();
    in_valid[0] = 1'b0;
    at_neg();
    chk("bp_next_data", 0, int'(out_data[0]), 16'h22);
    chk("bp_next_occ", 0, act_occ(0), 3);
    for (int i = 0; i < 4; i++) tick();

    // 3. Bubble collapse.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'h55;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    at_neg();
    chk("bub_single_data", 0, int'(out_data[0]), 16'h55);
    chk("bub_single_occ", 0, act_occ(0), 1);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h66;
    tick();
    in_data[0] = 16'h77;
    tick();
    in_valid[0] = 1'b0;
    at_neg();
    chk("bub_packed_occ", 0, act_occ(0), 3);
    chk("bub_packed_ready", 0, int'(in_ready[0]), 0);
    chk("bub_packed_data", 0, int'(out_data[0]), 16'h55);
    out_ready[0] = 1'b1;
    tick(); at_neg(); chk("bub_drain1", 0, int'(out_data[0]), 16'h66);
    tick(); at_neg(); chk("bub_drain2", 0, int'(out_data[0]), 16'h77);
    tick(); at_neg();
    chk("empty_valid", 0, int'(out_valid[0]), 0);
    chk("empty_data", 0, int'(out_data[0]), 0);
    tick();

    // 4. Flush accounting: 3 + 2 = 5, then +2 = 7, a held flush adds nothing more.
    fill(0, 3);
    flush_for(0, 1, 3);
    tick();
    fill(0, 2);
    flush_for(0, 1, 5);
    tick();
    fill(0, 2);
    flush_for(0, 2, 7);
    tick();

    // 5. Saturation on the 2-bit counter.
    fill(1, 3);
    flush_for(1, 1, 3);
    tick();
    fill(1, 3);
    flush_for(1, 1, 3);
    tick();

    // 6. Asynchronous reset while full, then DEPTH-edge latency.
    fill(0, 3);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 0, int'(out_valid[0]), 0);
    chk("areset_data", 0, int'(out_data[0]), 0);
    chk("areset_occ", 0, act_occ(0), 0);
    chk("areset_drop", 0, act_drop(0), 0);
    #2 reset = 1'b0;
    tick();
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = 16'hC3;
    tick();
    in_valid[0] = 1'b0;
    at_neg(); chk("lat_edge1", 0, int'(out_valid[0]), 0);
    tick();
    at_neg(); chk("lat_edge2", 0, int'(out_valid[0]), 0);
    tick();
    at_neg();
    chk("lat_edge3_valid", 0, int'(out_valid[0]), 1);
    chk("lat_edge3_data", 0, int'(out_data[0]), 16'hC3);
    tick();

    // Randomised traffic on all instances, alternating heavy and light consumers.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int id = 0; id < NDUT; id++) begin
        in_valid[id]  = ($urandom_range(0, 3) != 0);
        in_data[id]   = DW'($urandom);
        flush[id]     = ($urandom_range(0, 24) == 0);
        out_ready[id] = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    for (int id = 0; id < NDUT; id++) begin
      in_valid[id] = 1'b0;
      flush[id]    = 1'b0;
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
